// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - fetch FSM state encoding, address defaults and 6502 opcode length rule
package fetch_pkg;

  localparam logic [15:0] VECTOR_LO_DEFAULT = 16'hFFFC;
  localparam logic [15:0] RESET_PC_DEFAULT  = 16'hFFFC;

  typedef enum logic [2:0] {
    ST_VEC_LO = 3'd0,
    ST_VEC_HI = 3'd1,
    ST_OP     = 3'd2,
    ST_OPR_LO = 3'd3,
    ST_OPR_HI = 3'd4,
    ST_HOLD   = 3'd5
  } fetch_state_t;

  // Instruction length in bytes (1..3) from the cc/bbb fields of the opcode.
  function automatic logic [1:0] op_length(input logic [7:0] op);
    logic [2:0] bbb;
    logic [1:0] cc;
    bbb = op[4:2];
    cc  = op[1:0];
    op_length = 2'd1;
    case (cc)
      2'b01: begin
        if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) op_length = 2'd3;
        else op_length = 2'd2;
      end
      2'b10: begin
        if (bbb == 3'b011 || bbb == 3'b111) op_length = 2'd3;
        else if (bbb == 3'b001 || bbb == 3'b101 || op == 8'hA2) op_length = 2'd2;
        else op_length = 2'd1;
      end
      2'b00: begin
        if (op == 8'h20) op_length = 2'd3;
        else if (op == 8'h00 || op == 8'h40 || op == 8'h60) op_length = 2'd1;
        else if (bbb == 3'b000) op_length = 2'd2;
        else if (bbb == 3'b011 || bbb == 3'b111) op_length = 2'd3;
        else if (bbb == 3'b001 || bbb == 3'b100 || bbb == 3'b101) op_length = 2'd2;
        else op_length = 2'd1;
      end
      default: op_length = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/fetch_length_decode.sv
// rtl/fetch_length_decode.sv - combinational instruction length decode of the byte on the read bus
module fetch_length_decode
  import fetch_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] len
);

  assign len = op_length(opcode);

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - 6502 program counter and opcode/operand fetch FSM
// FETCH_VECTOR_EN: when defined, reset fetches the PC from the reset vector at VECTOR_LO.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
`ifdef FETCH_VECTOR_EN
  parameter logic [15:0] VECTOR_LO = VECTOR_LO_DEFAULT
`else
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
`endif
) (
  input  logic        FSM_Signal,
  input  logic        reset_FETCH,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  input  logic        pc_load,
  input  logic [15:0] pc_in,
  output logic [7:0]  OUT_opcode,
  output logic        load_IR,
  output logic [7:0]  operand_lo,
  output logic [7:0]  operand_hi,
  output logic [1:0]  instr_len,
  output logic        instr_valid,
  input  logic        instr_ack,
  output logic [15:0] pc_out
);

`ifdef FETCH_VECTOR_EN
  localparam logic [15:0]  PC_AT_RESET    = VECTOR_LO;
  localparam fetch_state_t STATE_AT_RESET = ST_VEC_LO;
`else
  localparam logic [15:0]  PC_AT_RESET    = RESET_PC;
  localparam fetch_state_t STATE_AT_RESET = ST_OP;
`endif

  fetch_state_t r_state;
  logic [15:0]  r_pc;
  logic [7:0]   r_opcode;
  logic [7:0]   r_opr_lo;
  logic [7:0]   r_opr_hi;
  logic [1:0]   r_len;
  logic         r_load_ir;
  logic         r_valid;

  logic [1:0]   w_len;
  logic [15:0]  w_addr;
  logic [15:0]  w_pc_inc;
  logic         w_in_vec;

  fetch_length_decode u_len (
    .opcode (mem_rdata),
    .len    (w_len)
  );

  assign w_pc_inc = r_pc + 16'd1;

  always_comb begin
    w_addr   = r_pc;
    w_in_vec = 1'b0;
`ifdef FETCH_VECTOR_EN
    if (r_state == ST_VEC_LO) begin
      w_addr   = VECTOR_LO;
      w_in_vec = 1'b1;
    end else if (r_state == ST_VEC_HI) begin
      w_addr   = VECTOR_LO + 16'd1;
      w_in_vec = 1'b1;
    end
`endif
  end

  always_ff @(posedge FSM_Signal or posedge reset_FETCH) begin
    if (reset_FETCH) begin
      r_state   <= STATE_AT_RESET;
      r_pc      <= PC_AT_RESET;
      r_opcode  <= 8'h00;
      r_opr_lo  <= 8'h00;
      r_opr_hi  <= 8'h00;
      r_len     <= 2'd0;
      r_load_ir <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_load_ir <= 1'b0;
      // A redirect drops whatever read is in flight; the vector fetch cannot be redirected.
      if (pc_load && !w_in_vec) begin
        r_pc    <= pc_in;
        r_state <= ST_OP;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
`ifdef FETCH_VECTOR_EN
          ST_VEC_LO: if (mem_ready) begin
            r_pc[7:0] <= mem_rdata;
            r_state   <= ST_VEC_HI;
          end
          ST_VEC_HI: if (mem_ready) begin
            r_pc[15:8] <= mem_rdata;
            r_state    <= ST_OP;
          end
`endif
          ST_OP: if (mem_ready) begin
            r_opcode  <= mem_rdata;
            r_len     <= w_len;
            r_load_ir <= 1'b1;
            r_pc      <= w_pc_inc;
            if (w_len == 2'd1) begin
              r_state <= ST_HOLD;
              r_valid <= 1'b1;
            end else begin
              r_state <= ST_OPR_LO;
            end
          end
          ST_OPR_LO: if (mem_ready) begin
            r_opr_lo <= mem_rdata;
            r_pc     <= w_pc_inc;
            if (r_len == 2'd3) begin
              r_state <= ST_OPR_HI;
            end else begin
              r_state <= ST_HOLD;
              r_valid <= 1'b1;
            end
          end
          ST_OPR_HI: if (mem_ready) begin
            r_opr_hi <= mem_rdata;
            r_pc     <= w_pc_inc;
            r_state  <= ST_HOLD;
            r_valid  <= 1'b1;
          end
          ST_HOLD: if (instr_ack) begin
            r_state <= ST_OP;
            r_valid <= 1'b0;
          end
          default: begin
            r_state <= ST_OP;
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mem_addr    = w_addr;
  assign mem_rd      = (r_state != ST_HOLD);
  assign OUT_opcode  = r_opcode;
  assign load_IR     = r_load_ir;
  assign operand_lo  = r_opr_lo;
  assign operand_hi  = r_opr_hi;
  assign instr_len   = r_len;
  assign instr_valid = r_valid;
  assign pc_out      = r_pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized-wait bench for instruction_fetch_unit against a memory-driven model
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        pc_load;
  logic [15:0] pc_in;
  logic [7:0]  OUT_opcode;
  logic        load_IR;
  logic [7:0]  operand_lo;
  logic [7:0]  operand_hi;
  logic [1:0]  instr_len;
  logic        instr_valid;
  logic        instr_ack;
  logic [15:0] pc_out;

  logic [7:0]  mem [0:65535];
  logic [15:0] m_pc;
  int          vectors = 0;
  int          miscompares = 0;

  instruction_fetch_unit dut (
    .FSM_Signal  (clk),
    .reset_FETCH (rst),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .pc_load     (pc_load),
    .pc_in       (pc_in),
    .OUT_opcode  (OUT_opcode),
    .load_IR     (load_IR),
    .operand_lo  (operand_lo),
    .operand_hi  (operand_hi),
    .instr_len   (instr_len),
    .instr_valid (instr_valid),
    .instr_ack   (instr_ack),
    .pc_out      (pc_out)
  );

  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  // Opcode byte count written as opcode patterns rather than field tests.
  function automatic int ref_len(input logic [7:0] op);
    casez (op)
      8'h20:                   return 3;
      8'h00, 8'h40, 8'h60:     return 1;
      8'b??????11:             return 1;
      8'b???011??, 8'b???111??,
      8'b???11001:             return 3;
      8'hA2:                   return 2;
      8'b??????01:             return 2;
      8'b???001??, 8'b???101??: return 2;
      8'b???00000, 8'b???10000: return 2;
      default:                 return 1;
    endcase
  endfunction

  function automatic logic [15:0] start_pc();
`ifdef FETCH_VECTOR_EN
    return {mem[16'hFFFD], mem[16'hFFFC]};
`else
    return 16'hFFFC;
`endif
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step_ready(input logic rdy);
    mem_ready = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch_and_check(input string tag);
    logic [7:0]  op;
    logic [15:0] a1, a2, prev;
    logic        rdy;
    int          len, nload;
    bit          done;
    nload = 0;
    done  = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      rdy  = ($urandom_range(0, 2) != 0);
      prev = pc_out;
      step_ready(rdy);
      if (load_IR) nload++;
      if (!rdy) chk({tag, "/wait_pc"}, pc_out, prev);
      if (instr_valid) done = 1;
    end
    chk({tag, "/done"}, 16'(done), 16'd1);
    op  = mem[m_pc];
    len = ref_len(op);
    a1  = m_pc + 16'd1;
    a2  = m_pc + 16'd2;
    chk({tag, "/opcode"}, 16'(OUT_opcode), 16'(op));
    chk({tag, "/len"}, 16'(instr_len), 16'(len));
    chk({tag, "/load_ir_pulses"}, 16'(nload), 16'd1);
    if (len >= 2) chk({tag, "/opr_lo"}, 16'(operand_lo), 16'(mem[a1]));
    if (len == 3) chk({tag, "/opr_hi"}, 16'(operand_hi), 16'(mem[a2]));
    m_pc = m_pc + 16'(len);
    chk({tag, "/pc_out"}, pc_out, m_pc);
  endtask

  task automatic hold_and_ack(input string tag, input bit do_ack);
    int n;
    n = $urandom_range(2, 5);
    instr_ack = 1'b0;
    for (int i = 0; i < n; i++) begin
      step_ready(1'($urandom_range(0, 1)));
      chk({tag, "/hold_valid"}, 16'(instr_valid), 16'd1);
      chk({tag, "/hold_rd"}, 16'(mem_rd), 16'd0);
      chk({tag, "/hold_load_ir"}, 16'(load_IR), 16'd0);
      chk({tag, "/hold_pc"}, pc_out, m_pc);
    end
    if (do_ack) begin
      instr_ack = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_ack = 1'b0;
      chk({tag, "/ack_valid"}, 16'(instr_valid), 16'd0);
      chk({tag, "/ack_rd"}, 16'(mem_rd), 16'd1);
      chk({tag, "/ack_addr"}, mem_addr, m_pc);
    end
  endtask

  task automatic redirect(input string tag, input logic [15:0] tgt, input logic with_ack);
    pc_load   = 1'b1;
    pc_in     = tgt;
    instr_ack = with_ack;
    mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pc_load   = 1'b0;
    instr_ack = 1'b0;
    chk({tag, "/addr"}, mem_addr, tgt);
    chk({tag, "/valid"}, 16'(instr_valid), 16'd0);
    chk({tag, "/pc_out"}, pc_out, tgt);
    m_pc = tgt;
  endtask

  task automatic run_to_load_ir(input string tag);
    bit seen;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step_ready(1'b1);
      if (load_IR) seen = 1;
    end
    chk({tag, "/load_ir_seen"}, 16'(seen), 16'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "/opcode"}, 16'(OUT_opcode), 16'd0);
    chk({tag, "/load_ir"}, 16'(load_IR), 16'd0);
    chk({tag, "/opr_lo"}, 16'(operand_lo), 16'd0);
    chk({tag, "/opr_hi"}, 16'(operand_hi), 16'd0);
    chk({tag, "/len"}, 16'(instr_len), 16'd0);
    chk({tag, "/valid"}, 16'(instr_valid), 16'd0);
    chk({tag, "/pc_out"}, pc_out, 16'hFFFC);
    chk({tag, "/addr"}, mem_addr, 16'hFFFC);
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2, input int n);
    logic [15:0] a1, a2;
    a1 = a + 16'd1;
    a2 = a + 16'd2;
    mem[a] = d0;
    if (n > 1) mem[a1] = d1;
    if (n > 2) mem[a2] = d2;
  endtask

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b0;
    pc_load   = 1'b0;
    pc_in     = 16'h0000;
    instr_ack = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    poke(16'hFFFC, 8'hEA, 8'hA9, 8'h42, 3);
    poke(16'hFFFF, 8'hA9, 8'h00, 8'h00, 1);
    poke(16'h0000, 8'h77, 8'hAD, 8'h00, 3);
    poke(16'h0003, 8'h20, 8'h00, 8'h00, 1);
    poke(16'h8000, 8'hEA, 8'hA9, 8'h42, 3);
    poke(16'h8003, 8'h4C, 8'h34, 8'h12, 3);
    poke(16'h8006, 8'h4C, 8'h11, 8'h22, 3);
    poke(16'hC000, 8'h4C, 8'h78, 8'h56, 3);
    poke(16'hD000, 8'hA9, 8'h55, 8'h00, 2);
    poke(16'hE000, 8'hA9, 8'h66, 8'h00, 2);

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst  = 1'b0;
    m_pc = start_pc();

    fetch_and_check("nop_fffc");
    hold_and_ack("nop_fffc", 1'b1);
    fetch_and_check("lda_fffd");
    hold_and_ack("lda_fffd", 1'b1);
    fetch_and_check("wrap_ffff");
    hold_and_ack("wrap_ffff", 1'b1);
    fetch_and_check("abs_0001");
    hold_and_ack("abs_0001", 1'b0);

    redirect("jmp8000", 16'h8000, 1'b0);
    fetch_and_check("len1");
    hold_and_ack("len1", 1'b1);
    fetch_and_check("len2");
    hold_and_ack("len2", 1'b1);
    fetch_and_check("len3");
    hold_and_ack("len3", 1'b1);

    run_to_load_ir("opr_hi_redirect");
    step_ready(1'b1);
    redirect("opr_hi_redirect", 16'hC000, 1'b0);
    fetch_and_check("after_redirect");
    redirect("hold_ack_redirect", 16'hD000, 1'b1);
    fetch_and_check("d000");
    hold_and_ack("d000", 1'b1);

    for (int i = 0; i < 12; i++) begin
      fetch_and_check($sformatf("rand%0d", i));
      hold_and_ack($sformatf("rand%0d", i), 1'b1);
    end

    redirect("to_e000", 16'hE000, 1'b0);
    run_to_load_ir("rst_opr_lo");
    mem_ready = 1'b0;
    rst       = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst  = 1'b0;
    m_pc = start_pc();
    fetch_and_check("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
